// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Groups the fetch front end's handshake and memory signals into one bundle.
// master : seen by fetch_unit (drives imem_addr and the delivery outputs)
// slave  : seen by the environment (drives stall, redirect and imem data)
// Signals:
//   stall_i     downstream cannot accept; hold the delivered instruction
//   pc_wr_en    redirect request from write-back
//   new_pc      redirect target
//   imem_addr   fetch address to the synchronous instruction memory
//   imem_rdata  memory data for the address issued the previous cycle
//   instr_o     delivered instruction (NOP when not valid)
//   pc_o        address of instr_o
//   valid_o     instr_o/pc_o valid
//   flush_o     clear downstream pipe registers this cycle
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   stall_i;
    logic                   pc_wr_en;
    logic [PC_WIDTH-1:0]    new_pc;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic [PC_WIDTH-1:0]    pc_o;
    logic                   valid_o;
    logic                   flush_o;

    modport master (
        input  stall_i, pc_wr_en, new_pc, imem_rdata,
        output imem_addr, instr_o, pc_o, valid_o, flush_o
    );

    modport slave (
        output stall_i, pc_wr_en, new_pc, imem_rdata,
        input  imem_addr, instr_o, pc_o, valid_o, flush_o
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch front end. Owns the PC, issues word addresses to a
// synchronous instruction memory (one cycle read latency) and hands the
// returned instruction plus its PC to the fetch/decode pipe register.
// A late redirect from write-back squashes in-flight work; a decode stall
// freezes fetch and parks the delivered instruction in a one-entry skid.
//
// Optional feature macro: FETCH_BRANCH_SHADOW_EN
//   When defined, delivering an instruction whose top nibble equals
//   BRANCH_OPCODE holds fetch for SHADOW_CYCLES cycles before resuming.
//
// Ports:
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    fetch_unit_if.master (stall/redirect in, imem bus, delivery out)
module fetch_unit #(
    parameter int                     PC_WIDTH      = 16,
    parameter int                     INSTR_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC      = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR     = '0,
    parameter logic [3:0]             BRANCH_OPCODE = 4'hF,
    parameter int                     SHADOW_CYCLES = 3
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    logic [PC_WIDTH-1:0]    pc_q;
    logic                   inflight_q;
    logic [PC_WIDTH-1:0]    inflight_pc_q;
    logic                   hold_valid_q;
    logic [INSTR_WIDTH-1:0] hold_instr_q;
    logic [PC_WIDTH-1:0]    hold_pc_q;

    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_pc;
    logic                   out_valid;
    logic                   run_state;
    logic                   br_take;
    logic                   fire;

    // The skid entry, once filled, takes precedence over the memory path:
    // during a stall the memory is already returning a newer word.
    always_comb begin
        out_instr = bus.imem_rdata;
        out_pc    = inflight_pc_q;
        if (hold_valid_q) begin
            out_instr = hold_instr_q;
            out_pc    = hold_pc_q;
        end
    end

    // A redirect in the same cycle invalidates whatever is being delivered.
    assign out_valid     = (hold_valid_q | inflight_q) & ~bus.pc_wr_en;
    assign bus.valid_o   = out_valid;
    assign bus.instr_o   = out_valid ? out_instr : NOP_INSTR;
    assign bus.pc_o      = out_pc;
    assign bus.flush_o   = bus.pc_wr_en;
    assign bus.imem_addr = pc_q;

    assign fire = run_state & ~bus.stall_i & ~bus.pc_wr_en & ~br_take;

`ifdef FETCH_BRANCH_SHADOW_EN
    localparam bit SHADOW_ON = (SHADOW_CYCLES > 0);
    localparam int CNT_W     = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;

    typedef enum logic {
        RUN,
        SHADOW
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    assign run_state = (state == RUN);
    assign br_take   = SHADOW_ON & out_valid & ~bus.stall_i &
                       (out_instr[INSTR_WIDTH-1 -: 4] == BRANCH_OPCODE);

    // Shadow sequencer: a delivered branch parks fetch for SHADOW_CYCLES
    // cycles; a redirect always drops straight back to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            count <= '0;
        end else if (bus.pc_wr_en) begin
            state <= RUN;
            count <= '0;
        end else if (state == SHADOW) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                state <= RUN;
            end
        end else if (br_take) begin
            state <= SHADOW;
            count <= CNT_W'(SHADOW_CYCLES);
        end
    end
`else
    logic unused_shadow_cfg;

    assign run_state         = 1'b1;
    assign br_take           = 1'b0;
    assign unused_shadow_cfg = ^{BRANCH_OPCODE, SHADOW_CYCLES};
`endif

    // Fetch datapath. Priority: reset, redirect, stall, then issue.
    // The skid captures on the first stall cycle only, while imem_rdata
    // still belongs to inflight_pc_q; it drains on the first free cycle,
    // in which the next address is issued so no word is lost or repeated.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            hold_valid_q  <= 1'b0;
            hold_instr_q  <= NOP_INSTR;
            hold_pc_q     <= '0;
        end else if (bus.pc_wr_en) begin
            pc_q         <= bus.new_pc;
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
        end else if (bus.stall_i) begin
            if (inflight_q && !hold_valid_q) begin
                hold_valid_q <= 1'b1;
                hold_instr_q <= bus.imem_rdata;
                hold_pc_q    <= inflight_pc_q;
            end
        end else begin
            hold_valid_q <= 1'b0;
            if (fire) begin
                pc_q          <= pc_q + PC_WIDTH'(1);
                inflight_q    <= 1'b1;
                inflight_pc_q <= pc_q;
            end else begin
                inflight_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. dut_a (RESET_PC=0) carries the main
// sequence; dut_b (RESET_PC=0xFFFF) checks the PC wrap after reset.
// A scoreboard queue holds the expected {pc, instr} stream; every
// instruction accepted downstream (valid_o & !stall_i) is popped and
// compared. Expectations for the branch section follow the
// FETCH_BRANCH_SHADOW_EN macro.
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    logic branch_mode;
    logic mon_en;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) bus_a ();
    fetch_unit_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) bus_b ();

    fetch_unit #(.RESET_PC(16'h0000)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    // Instruction memory image: a ^ 0xA500, with a branch at 5 when enabled.
    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic br);
        if (br && (a == 16'h0005)) begin
            return 16'hF005;
        end
        return a ^ 16'hA500;
    endfunction

    // Synchronous read: data for the address seen at the previous edge.
    always @(posedge clk) begin
        bus_a.imem_rdata <= mem_word(bus_a.imem_addr, branch_mode);
        bus_b.imem_rdata <= mem_word(bus_b.imem_addr, 1'b0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stall, input logic wr,
                                 input logic [15:0] npc);
        reset_a        = rst;
        bus_a.stall_i  = stall;
        bus_a.pc_wr_en = wr;
        bus_a.new_pc   = npc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [15:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc, branch_mode);
        exp_q.push_back(e);
    endtask

    // Scoreboard consumer: sampled mid-cycle, pops on every accepted word.
    always @(negedge clk) begin
        if (mon_en && !reset_a && bus_a.valid_o && !bus_a.stall_i) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("[TB] FAIL sb_extra observed pc=%0h expected=none", bus_a.pc_o);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_pc", 32'(bus_a.pc_o), 32'(e.pc));
                checkOutput("sb_instr", 32'(bus_a.instr_o), 32'(e.instr));
            end
        end
    end

    initial begin
        mon_en      = 1'b0;
        branch_mode = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        reset_b        = 1'b1;
        bus_b.stall_i  = 1'b0;
        bus_b.pc_wr_en = 1'b0;
        bus_b.new_pc   = 16'h0000;
        repeat (3) step();

        // Reset state
        checkOutput("rst_valid", 32'(bus_a.valid_o), 32'd0);
        checkOutput("rst_instr", 32'(bus_a.instr_o), 32'h0000);
        checkOutput("rst_pc", 32'(bus_a.pc_o), 32'h0000);
        checkOutput("rst_flush", 32'(bus_a.flush_o), 32'd0);
        checkOutput("rst_addr", 32'(bus_a.imem_addr), 32'h0000);
        checkOutput("rst_addr_b", 32'(bus_b.imem_addr), 32'hFFFF);

        // Sequential fetch from reset, then a three-cycle stall on pc 4
        for (int i = 0; i < 6; i++) pushExp(16'(i));
        mon_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        reset_b = 1'b0;
        #1;
        checkOutput("rel_addr", 32'(bus_a.imem_addr), 32'h0000);
        checkOutput("rel_valid", 32'(bus_a.valid_o), 32'd0);
        step();
        checkOutput("first_valid", 32'(bus_a.valid_o), 32'd1);
        checkOutput("first_pc", 32'(bus_a.pc_o), 32'h0000);
        checkOutput("first_instr", 32'(bus_a.instr_o), 32'hA500);
        checkOutput("first_addr", 32'(bus_a.imem_addr), 32'h0001);
        checkOutput("wrap_addr_b", 32'(bus_b.imem_addr), 32'h0000);
        checkOutput("wrap_pc_b0", 32'(bus_b.pc_o), 32'hFFFF);
        checkOutput("wrap_instr_b0", 32'(bus_b.instr_o), 32'h5AFF);
        step();
        checkOutput("wrap_pc_b1", 32'(bus_b.pc_o), 32'h0000);
        checkOutput("wrap_valid_b1", 32'(bus_b.valid_o), 32'd1);
        step();
        step();
        step();
        checkOutput("pre_stall_pc", 32'(bus_a.pc_o), 32'h0004);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("stall_pc", 32'(bus_a.pc_o), 32'h0004);
            checkOutput("stall_instr", 32'(bus_a.instr_o), 32'hA504);
            checkOutput("stall_addr", 32'(bus_a.imem_addr), 32'h0005);
        end
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("release_pc", 32'(bus_a.pc_o), 32'h0004);
        step();
        checkOutput("post_stall_pc5", 32'(bus_a.pc_o), 32'h0005);
        checkOutput("post_stall_addr", 32'(bus_a.imem_addr), 32'h0006);
        step();
        checkOutput("post_stall_pc6", 32'(bus_a.pc_o), 32'h0006);
        checkOutput("sb_drain_stall", 32'(exp_q.size()), 32'd0);

        // Redirect while stalled with the skid full
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        step();
        pushExp(16'h0040);
        pushExp(16'h0041);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040);
        #1;
        checkOutput("redir_flush", 32'(bus_a.flush_o), 32'd1);
        checkOutput("redir_valid", 32'(bus_a.valid_o), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("redir_addr", 32'(bus_a.imem_addr), 32'h0040);
        checkOutput("redir_gap_valid", 32'(bus_a.valid_o), 32'd0);
        step();
        checkOutput("redir_pc", 32'(bus_a.pc_o), 32'h0040);
        checkOutput("redir_pc_valid", 32'(bus_a.valid_o), 32'd1);
        step();
        step();

        // Reset while stalled with the skid full
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        step();
        checkOutput("hold_pre_rst_pc", 32'(bus_a.pc_o), 32'h0042);
        checkOutput("sb_drain_redir", 32'(exp_q.size()), 32'd0);
        branch_mode = 1'b1;
        for (int i = 0; i < 7; i++) pushExp(16'(i));
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        checkOutput("midrst_valid", 32'(bus_a.valid_o), 32'd0);
        checkOutput("midrst_addr", 32'(bus_a.imem_addr), 32'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        checkOutput("midrst_first_pc", 32'(bus_a.pc_o), 32'h0000);

        // Branch at pc 5
        repeat (5) step();
        checkOutput("br_pc", 32'(bus_a.pc_o), 32'h0005);
        checkOutput("br_instr", 32'(bus_a.instr_o), 32'hF005);
`ifdef FETCH_BRANCH_SHADOW_EN
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("shadow_valid", 32'(bus_a.valid_o), 32'd0);
        end
`endif
        step();
        checkOutput("after_br_pc", 32'(bus_a.pc_o), 32'h0006);
        checkOutput("after_br_valid", 32'(bus_a.valid_o), 32'd1);
        step();
        checkOutput("sb_drain_br", 32'(exp_q.size()), 32'd0);
        pushExp(16'h0004);
        pushExp(16'h0005);
`ifndef FETCH_BRANCH_SHADOW_EN
        pushExp(16'h0006);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0004);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        checkOutput("rebr_pc4", 32'(bus_a.pc_o), 32'h0004);
        step();
        checkOutput("rebr_pc5", 32'(bus_a.pc_o), 32'h0005);
        step();
`ifdef FETCH_BRANCH_SHADOW_EN
        checkOutput("shadow_redir_valid", 32'(bus_a.valid_o), 32'd0);
`else
        checkOutput("nobr_pc6", 32'(bus_a.pc_o), 32'h0006);
        step();
`endif
        pushExp(16'h0020);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0020);
        #1;
        checkOutput("redir20_flush", 32'(bus_a.flush_o), 32'd1);
        checkOutput("redir20_valid", 32'(bus_a.valid_o), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("redir20_addr", 32'(bus_a.imem_addr), 32'h0020);
        step();
        checkOutput("redir20_pc", 32'(bus_a.pc_o), 32'h0020);
        checkOutput("redir20_pc_valid", 32'(bus_a.valid_o), 32'd1);
        step();
        mon_en = 1'b0;
        checkOutput("sb_drain_end", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
